decoder_input_capture: RTL and testbench
========================================

// Module: decoder_input_capture
// PURPOSE
//  Front-end stage that feeds the 7-bit decoder core's io_in bus. Asynchronous pad inputs
//  are synchronised and debounced. A code is committed once it has been stable, and the
//  block then holds it with a valid/ready handshake until the decoder consumes it.
//  Only changes in the stable code are forwarded, so the decoder sees one transfer per
//  distinct settled pattern.
// PARAMETERS
//  WIDTH          7   width of pad bus and committed code
//  SYNC_STAGES    2   flip-flop synchroniser depth, >=2
//  STABLE_CYCLES  4   consecutive equal synchronised samples required to commit, >=1
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      asynchronous active-low reset
//  en_i     in   1      capture enable; 0 freezes candidate tracking (handshake still works)
//  pin_i    in   WIDTH  raw asynchronous pad bus
//  code_o   out  WIDTH  committed code presented to decoder (drives decoder io_in)
//  valid_o  out  1      code_o holds an unconsumed code
//  ready_i  in   1      decoder accepts code_o this cycle
//  busy_o   out  1      candidate differs from last committed code and is still settling
//  drop_o   out  1      one-cycle pulse: stable code rejected (CONFIGURATION); else const 0
// BEHAVIOUR
//  - Reset (async assert, sync release): all regs 0; code_o=0, valid_o=0, busy_o=0, drop_o=0;
//    has_last=0, so the first settled code after reset commits, even if it is all-zero.
//  - Sync: pin_i passes through an SYNC_STAGES-deep flop chain; sync_q is the last stage.
//  - Debounce, when en_i=1: if sync_q!=cand, load cand<=sync_q and cnt<=0.
//    Else cnt increments and saturates at STABLE_CYCLES-1.
//  - Commit condition: cnt==STABLE_CYCLES-1, sync_q==cand, state!=PEND, and
//    (!has_last || cand!=last).
//  - FSM:
//    IDLE: cand==last and no pending code. Goes to SETTLE when cand is loaded with a new value.
//    SETTLE: counting. On commit, go to PEND with code_o<=cand, last<=cand, has_last<=1,
//      valid_o<=1. Return to IDLE if cand reverts to last.
//    PEND: valid_o=1 and code_o is stable. On valid_o&&ready_i, clear valid_o and go to
//      IDLE, or to SETTLE if cand!=last.
//  - Latency: with a single pin_i change and defaults, valid_o rises after the 7th rising
//    edge following the change (SYNC_STAGES + STABLE_CYCLES + 1).
//  - While in PEND, debounce continues. A newer stable code waits and commits on the edge
//    after acceptance, since cnt is already saturated. Codes are never overwritten or lost
//    except by glitch filtering.
//  - Glitch: any sync_q change before saturation restarts cnt; a pulse shorter than
//    STABLE_CYCLES samples never commits.
//  - ready_i while valid_o=0 is ignored. ready_i held high gives at most one transfer per
//    commit.
//  - en_i=0: cand and cnt hold and the commit condition is false. A pending code can still
//    be accepted.
//  - busy_o = (state==SETTLE).
//  - Reset mid-handshake drops the pending code; valid_o falls immediately on rst_n low.
// CONFIGURATION
//  DEC_PARITY_EN defined:
//   - bit WIDTH-1 is odd parity over bits WIDTH-2:0, so ^code must equal 1.
//   - A code that meets the commit condition but fails parity is not committed.
//   - drop_o pulses for 1 cycle, last is loaded with the bad code so it pulses once per
//     bad code, and state returns to IDLE.
//  DEC_PARITY_EN undefined:
//   - every settled code commits; drop_o tied 0.
// TESTING
//  1. pin_i=7'b1010111 held from reset release, ready_i=1 -> valid_o high 1 cycle after
//     edge 7, code_o=7'b1010111; with DEC_PARITY_EN, still commits (odd parity OK).
//  2. 3-cycle glitch 7'h00->7'h7F->7'h00 after settling on 7'h00 -> no valid_o and no code_o
//     change; busy_o high during glitch then low.
//  3. ready_i=0, settle 7'h15 then change to 7'h2A -> code_o stays 7'h15 with valid_o=1;
//     raise ready_i for 1 cycle -> next cycle valid_o=1 with code_o=7'h2A.
//  4. Same code re-settled after acceptance (7'h15, glitch shorter than STABLE_CYCLES) ->
//     no second transfer.
//  5. DEC_PARITY_EN, pin_i=7'b0000011 (even parity) -> drop_o single pulse, valid_o stays
//     0; without macro -> commits normally.
//  6. Assert rst_n low while valid_o=1 -> code_o=0 and valid_o=0 asynchronously; after
//     release, current stable pin_i recommits after 7 edges.

Source files
------------

// File: rtl/decoder_input_capture.sv
// -----------------------------------------------------------------------------
// decoder_input_capture
//
// Front-end stage for the 7-bit decoder core's io_in bus. Raw pad inputs are
// synchronised, debounced, and a settled code is committed once. The committed
// code is held with a valid/ready handshake until the decoder consumes it. Only
// changes in the settled code are forwarded, so the decoder sees one transfer
// per distinct settled pattern.
//
// Ports:
//   clk      in   1      system clock
//   rst_n    in   1      asynchronous active-low reset
//   en_i     in   1      capture enable; 0 freezes candidate tracking
//   pin_i    in   WIDTH  raw asynchronous pad bus
//   code_o   out  WIDTH  committed code presented to the decoder
//   valid_o  out  1      code_o holds an unconsumed code
//   ready_i  in   1      decoder accepts code_o this cycle
//   busy_o   out  1      candidate differs from last committed code, settling
//   drop_o   out  1      one-cycle pulse when a settled code fails parity
//
// Build option:
//   DEC_PARITY_EN  when defined, bit WIDTH-1 is odd parity over the lower bits;
//                  settled codes with bad parity are dropped (drop_o pulses)
//                  instead of committed. When undefined, drop_o is tied 0.
// -----------------------------------------------------------------------------
module decoder_input_capture #(
  parameter int WIDTH         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] code_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             drop_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_PEND   = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_last;
  logic             r_has_last;
  logic [WIDTH-1:0] r_code;
  logic             r_valid;
  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_cand_next;
  logic             w_load;
  logic             w_new_code;
  logic             w_settled;
  logic             w_parity_ok;
  logic             w_commit;
  logic             w_reject;
  logic             w_accept;

  // Pad synchroniser chain; the last stage is the only one the logic looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Debounce: any change of the synchronised value restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (en_i) begin
      if (w_sync_q != r_cand) begin
        r_cand <= w_sync_q;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef DEC_PARITY_EN
  assign w_parity_ok = ^r_cand;
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_load      = en_i && (w_sync_q != r_cand);
  assign w_cand_next = w_load ? w_sync_q : r_cand;
  assign w_new_code  = !r_has_last || (r_cand != r_last);
  // A settled code may commit from IDLE too: right after reset the candidate
  // is already 0 and never reloads, yet an all-zero pad bus must still commit.
  assign w_settled   = en_i && (r_cnt == CNT_MAX) && (w_sync_q == r_cand) &&
                       (r_state != S_PEND) && w_new_code;
  assign w_commit    = w_settled && w_parity_ok;
  assign w_reject    = w_settled && !w_parity_ok;
  assign w_accept    = r_valid && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decisions use the candidate value that will be present after
  // this edge, so a same-cycle reload is never missed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_state_next = S_PEND;
        end else if (w_reject) begin
          w_state_next = S_IDLE;
        end else if (w_load && (!r_has_last || (w_sync_q != r_last))) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_commit) begin
          w_state_next = S_PEND;
        end else if (w_reject) begin
          w_state_next = S_IDLE;
        end else if (w_load && r_has_last && (w_sync_q == r_last)) begin
          w_state_next = S_IDLE;
        end
      end
      S_PEND: begin
        if (w_accept) begin
          w_state_next = (w_cand_next != r_last) ? S_SETTLE : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Committed code and handshake; commit and accept are exclusive because
  // commit is blocked while a code is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_last     <= '0;
      r_has_last <= 1'b0;
      r_valid    <= 1'b0;
    end else if (w_commit) begin
      r_code     <= r_cand;
      r_last     <= r_cand;
      r_has_last <= 1'b1;
      r_valid    <= 1'b1;
    end else begin
      if (w_reject) begin
        r_last     <= r_cand;
        r_has_last <= 1'b1;
      end
      if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef DEC_PARITY_EN
  logic r_drop;

  // Remembering the rejected code in last keeps the pulse to one per bad code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_reject;
    end
  end

  assign drop_o = r_drop;
`else
  assign drop_o = 1'b0;
`endif

  assign code_o  = r_code;
  assign valid_o = r_valid;
  assign busy_o  = (r_state == S_SETTLE);

endmodule

// File: tb/tb_decoder_input_capture.sv
// -----------------------------------------------------------------------------
// tb_decoder_input_capture
//
// Self-checking bench for decoder_input_capture. Expected codes are pushed to a
// scoreboard queue when pads are driven and popped when valid_o is observed.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_decoder_input_capture;

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic [6:0] pin_i;
  logic [6:0] code_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       drop_o;

  int vectors = 0;
  int errors  = 0;
  int xferCount = 0;
  int dropCount = 0;
  logic [6:0] expQ [$];
  logic [6:0] expCode = 7'h00;

  decoder_input_capture dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .pin_i   (pin_i),
    .code_o  (code_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .drop_o  (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and drop observers
  always @(posedge clk) begin
    if (rst_n && valid_o && ready_i) xferCount++;
  end

  always @(negedge clk) begin
    if (drop_o) dropCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for valid_o; ok=0 when the budget expires.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_pop(output logic [6:0] e, output bit have);
    have = (expQ.size() != 0);
    e = have ? expQ.pop_front() : 7'hxx;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en_i = 1'b1; ready_i = 1'b1; pin_i = 7'b1010111;
    @(negedge clk);
    vectors++;
    if (code_o !== 7'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 || drop_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got code=%h valid=%b busy=%b drop=%b expected 00/0/0/0",
               code_o, valid_o, busy_o, drop_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency;
    logic [6:0] e; bit have;
    int base;
    base = xferCount;
    expQ.push_back(7'b1010111);
    tick(6);
    vectors++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_edge6: got valid=%b busy=%b expected valid=0 busy=1", valid_o, busy_o);
    end
    tick(1);
    sb_pop(e, have);
    vectors++;
    if (valid_o !== 1'b1 || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL latency_edge7: got valid=%b code=%h expected valid=1 code=%h", valid_o, code_o, e);
    end
    expCode = 7'b1010111;
    tick(1);
    vectors++;
    if (valid_o !== 1'b0 || xferCount !== base + 1) begin
      errors++;
      $display("[TB] FAIL single_transfer: got valid=%b xfers=%0d expected valid=0 xfers=%0d",
               valid_o, xferCount - base, 1);
    end
  endtask

  task automatic test_glitch;
    logic [6:0] e; bit have, ok;
    int base;
    pin_i = 7'h00;
`ifdef DEC_PARITY_EN
    tick(14);
`else
    expQ.push_back(7'h00);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL zero_commit: got ok=%b code=%h expected code=%h", ok, code_o, e);
    end
    expCode = 7'h00;
`endif
    tick(2);
    base = xferCount;
    pin_i = 7'h7F;
    tick(3);
    vectors++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy: got busy=%b expected 1", busy_o);
    end
    pin_i = 7'h00;
    tick(10);
    vectors++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || code_o !== expCode || xferCount !== base) begin
      errors++;
      $display("[TB] FAIL glitch_filtered: got busy=%b valid=%b code=%h xfers=%0d expected 0/0/%h/0",
               busy_o, valid_o, code_o, xferCount - base, expCode);
    end
  endtask

  task automatic test_backpressure;
    logic [6:0] e; bit have, ok;
    ready_i = 1'b0;
    pin_i = 7'h15;
    expQ.push_back(7'h15);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL bp_first: got ok=%b code=%h expected %h", ok, code_o, e);
    end
    pin_i = 7'h2A;
    expQ.push_back(7'h2A);
    tick(12);
    vectors++;
    if (valid_o !== 1'b1 || code_o !== 7'h15) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid=%b code=%h expected 1/15", valid_o, code_o);
    end
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept: got valid=%b expected 0", valid_o);
    end
    tick(1);
    sb_pop(e, have);
    vectors++;
    if (valid_o !== 1'b1 || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL bp_next: got valid=%b code=%h expected 1/%h", valid_o, code_o, e);
    end
    expCode = 7'h2A;
    ready_i = 1'b1;
    tick(1);
  endtask

  task automatic test_resettle;
    logic [6:0] e; bit have, ok;
    int base;
    ready_i = 1'b1;
    pin_i = 7'h15;
    expQ.push_back(7'h15);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL resettle_first: got ok=%b code=%h expected %h", ok, code_o, e);
    end
    expCode = 7'h15;
    tick(2);
    base = xferCount;
    pin_i = 7'h2A;
    tick(2);
    pin_i = 7'h15;
    tick(12);
    vectors++;
    if (xferCount !== base || valid_o !== 1'b0 || busy_o !== 1'b0 || code_o !== expCode) begin
      errors++;
      $display("[TB] FAIL resettle_none: got xfers=%0d valid=%b busy=%b code=%h expected 0/0/0/%h",
               xferCount - base, valid_o, busy_o, code_o, expCode);
    end
  endtask

  task automatic test_parity;
    int baseDrop, baseX;
`ifndef DEC_PARITY_EN
    logic [6:0] e; bit have, ok;
`endif
    baseDrop = dropCount;
    baseX = xferCount;
    pin_i = 7'b0000011;
`ifdef DEC_PARITY_EN
    tick(14);
    vectors++;
    if (dropCount !== baseDrop + 1 || xferCount !== baseX || valid_o !== 1'b0 || code_o !== expCode) begin
      errors++;
      $display("[TB] FAIL parity_drop: got drops=%0d xfers=%0d valid=%b code=%h expected 1/0/0/%h",
               dropCount - baseDrop, xferCount - baseX, valid_o, code_o, expCode);
    end
`else
    expQ.push_back(7'b0000011);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL even_commit: got ok=%b code=%h expected %h", ok, code_o, e);
    end
    expCode = 7'b0000011;
    tick(2);
    vectors++;
    if (dropCount !== baseDrop || xferCount !== baseX + 1) begin
      errors++;
      $display("[TB] FAIL no_drop: got drops=%0d xfers=%0d expected 0/1",
               dropCount - baseDrop, xferCount - baseX);
    end
`endif
  endtask

  task automatic test_enable;
    logic [6:0] e; bit have, ok;
    en_i = 1'b0;
    pin_i = 7'h07;
    tick(12);
    vectors++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || code_o !== expCode) begin
      errors++;
      $display("[TB] FAIL enable_freeze: got busy=%b valid=%b code=%h expected 0/0/%h",
               busy_o, valid_o, code_o, expCode);
    end
    en_i = 1'b1;
    expQ.push_back(7'h07);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL enable_resume: got ok=%b code=%h expected %h", ok, code_o, e);
    end
    expCode = 7'h07;
    tick(2);
  endtask

  task automatic test_reset_mid;
    logic [6:0] e; bit have, ok;
    ready_i = 1'b0;
    pin_i = 7'h15;
    expQ.push_back(7'h15);
    wait_valid(ok);
    sb_pop(e, have);
    vectors++;
    if (!ok || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL rstmid_pending: got ok=%b code=%h expected %h", ok, code_o, e);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || code_o !== 7'h00) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got valid=%b code=%h expected 0/00", valid_o, code_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(7'h15);
    tick(6);
    vectors++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_edge6: got valid=%b expected 0", valid_o);
    end
    tick(1);
    sb_pop(e, have);
    vectors++;
    if (valid_o !== 1'b1 || !have || code_o !== e) begin
      errors++;
      $display("[TB] FAIL rstmid_recommit: got valid=%b code=%h expected 1/%h", valid_o, code_o, e);
    end
    ready_i = 1'b1;
    tick(1);
    vectors++;
    if (valid_o !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain: got valid=%b queued=%0d expected 0/0", valid_o, expQ.size());
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_backpressure;
    test_resettle;
    test_parity;
    test_enable;
    test_reset_mid;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
